ac_sweep_source: RTL and testbench
==================================

Name: ac_sweep_source

Overview:
- Digital stimulus end of the AC group-delay measurement chain.
- Steps a frequency tuning word (FTW) linearly across a programmed number of points.
- Generates a phase-continuous NCO phase sample stream at each point.
- Handshakes each completed point to the downstream S21/phase receiver, which computes unwrapped phase and the group delay by finite difference over the frequency step.

Parameters:
- FW, 32, FTW and phase-accumulator width
- PW, 16, output phase sample width (upper PW bits of accumulator)
- NW, 10, point-count/index width
- CW, 16, settle/dwell counter width

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin sweep (pulse; sampled only in IDLE)
- abort  in  1  terminate sweep
- f_start  in  FW  FTW of point 0
- f_step  in  FW  FTW increment per point
- n_points  in  NW  number of points
- settle_cycles  in  CW  cycles after each frequency change before measurement
- dwell_cycles  in  CW  measurement window length
- point_ack  in  1  receiver has consumed current point
- ftw_out  out  FW  current tuning word
- phase_out  out  PW  NCO phase sample
- point_idx  out  NW  current point index
- meas_en  out  1  receiver integration window
- point_valid  out  1  point complete, awaiting ack
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end

Behaviour:
- Reset: the following are all 0 and state=IDLE:
  - ftw_out, phase_out, accumulator, point_idx, meas_en, point_valid, busy, done
- Config latching: config inputs are latched on the accepted start. Later changes are ignored until the next sweep.
- States: IDLE, SETTLE, DWELL, WAIT_ACK, DONE.
- IDLE + start:
  - n_points==0 -> DONE (no point produced).
  - else -> SETTLE, with ftw_out=f_start, point_idx=0, busy=1 from the next cycle.
- SETTLE:
  - Counts settle_cycles cycles, then -> DWELL.
  - settle_cycles==0 -> DWELL on the next cycle (one-cycle pass-through).
- DWELL:
  - meas_en=1 for exactly max(dwell_cycles,1) cycles, then -> WAIT_ACK.
- WAIT_ACK:
  - point_valid=1, held until point_ack is sampled high.
  - On ack with point_idx==n_points-1 -> DONE.
  - On ack otherwise -> SETTLE, with point_idx+1 and ftw_out+=f_step.
  - point_valid drops the cycle after ack.
- DONE: done=1 for one cycle, busy=0, -> IDLE. ftw_out and accumulator hold their values.
- NCO:
  - acc <= acc + ftw_out every cycle while busy, modulo 2^FW.
  - phase_out = acc[FW-1:FW-PW], registered (one cycle behind acc).
  - No accumulator reset on frequency step (phase-continuous).
- FTW arithmetic: modulo 2^FW, so f_start + k*f_step wraps silently. f_step==0 is legal (repeated point).
- Ignored inputs:
  - point_ack outside WAIT_ACK.
  - start when not IDLE.
- abort:
  - Wins over all other events in the same cycle.
  - Next cycle: state=IDLE; busy, meas_en and point_valid are 0; done is not asserted; accumulator and ftw_out cleared.
- rst mid-sweep: identical to the reset values above, regardless of state.
- Simultaneous start and abort in IDLE: abort wins and the sweep does not start.

Decomposition:
- Package ac_sweep_pkg:
  - state enum
  - default widths FW/PW/NW/CW
  - a localparam for the minimum dwell (1)
- Sub-module ac_sweep_nco: phase accumulator plus the registered phase_out truncation, with ports clk, rst, en, clr, ftw, phase.
- Top holds the FSM, counters and FTW stepping.

Test Plan:
- Basic sweep: f_start=0x1000_0000, f_step=0x0100_0000, n_points=3, settle=2, dwell=4, ack 1 cycle after each point_valid -> ftw_out sequence 0x10000000, 0x11000000, 0x12000000; meas_en high 4 cycles per point; point_idx 0,1,2; single done pulse; busy low afterward.
- NCO: ftw fixed at 0x4000_0000, PW=16 -> phase_out cycles 0x0000, 0x4000, 0x8000, 0xC000, 0x0000; continuity across a step to 0x2000_0000 with no phase jump.
- Edge counts: n_points=0 -> done one cycle after start, no point_valid. settle=0, dwell=0 -> each point spends exactly 1 SETTLE and 1 DWELL cycle.
- Backpressure: withhold point_ack 10 cycles -> point_valid stays high, FTW and point_idx stable; a stray ack during DWELL is ignored.
- Wrap: f_start=0xFFFF_FF00, f_step=0x200, n_points=2 -> second ftw_out=0x0000_0100.
- Abort/reset: abort during DWELL of point 1 -> next cycle IDLE with outputs 0 and no done. rst in WAIT_ACK -> all outputs 0. A new start then restarts at point 0.

Source files
------------

// File: rtl/ac_sweep_pkg.sv
// Shared state encoding, default widths and the minimum window length for the AC sweep source.
// Latency and backpressure: not applicable, this file holds types and constants only.
package ac_sweep_pkg;

  localparam int DEF_FW = 32;
  localparam int DEF_PW = 16;
  localparam int DEF_NW = 10;
  localparam int DEF_CW = 16;

  localparam int MIN_DWELL = 1;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    DWELL,
    WAIT_ACK,
    DONE
  } state_t;

endpackage

// File: rtl/ac_sweep_nco.sv
// Phase accumulator with a registered, truncated phase output. phase lags acc by one cycle.
// Backpressure: none. The accumulator runs freely while en is high and is never cleared on a tuning-word change.
module ac_sweep_nco
  import ac_sweep_pkg::*;
#(
  parameter int FW = DEF_FW,
  parameter int PW = DEF_PW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [FW-1:0] ftw,
  output logic [PW-1:0] phase
);

  logic [FW-1:0] acc;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc   <= '0;
      phase <= '0;
    end else begin
      if (en) acc <= acc + ftw;
      phase <= acc[FW-1 -: PW];
    end
  end

endmodule

// File: rtl/ac_sweep_source.sv
// Frequency-stepped NCO stimulus that settles, dwells and then hands each point to the receiver.
// Outputs are registered. point_valid holds until point_ack. abort or rst clears the sweep on the next edge.
module ac_sweep_source
  import ac_sweep_pkg::*;
#(
  parameter int FW = DEF_FW,
  parameter int PW = DEF_PW,
  parameter int NW = DEF_NW,
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [FW-1:0] f_start,
  input  logic [FW-1:0] f_step,
  input  logic [NW-1:0] n_points,
  input  logic [CW-1:0] settle_cycles,
  input  logic [CW-1:0] dwell_cycles,
  input  logic          point_ack,
  output logic [FW-1:0] ftw_out,
  output logic [PW-1:0] phase_out,
  output logic [NW-1:0] point_idx,
  output logic          meas_en,
  output logic          point_valid,
  output logic          busy,
  output logic          done
);

  state_t        state;
  logic [FW-1:0] step_q;
  logic [NW-1:0] last_idx;
  logic [CW-1:0] settle_q;
  logic [CW-1:0] dwell_q;
  logic [CW-1:0] cnt;

  // Down-counter preload. A zero length still spends one cycle in the state.
  function automatic logic [CW-1:0] cnt_load(input logic [CW-1:0] len);
    return (len > CW'(MIN_DWELL)) ? len - CW'(MIN_DWELL) : '0;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q   <= '0;
      last_idx <= '0;
      settle_q <= '0;
      dwell_q  <= '0;
    end else if (state == IDLE && start && !abort) begin
      step_q   <= f_step;
      last_idx <= n_points - NW'(1);
      settle_q <= settle_cycles;
      dwell_q  <= dwell_cycles;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state       <= IDLE;
      ftw_out     <= '0;
      point_idx   <= '0;
      cnt         <= '0;
      meas_en     <= 1'b0;
      point_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (n_points == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= SETTLE;
              ftw_out   <= f_start;
              point_idx <= '0;
              cnt       <= cnt_load(settle_cycles);
              busy      <= 1'b1;
            end
          end
        end
        SETTLE: begin
          if (cnt == '0) begin
            state   <= DWELL;
            cnt     <= cnt_load(dwell_q);
            meas_en <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DWELL: begin
          if (cnt == '0) begin
            state       <= WAIT_ACK;
            meas_en     <= 1'b0;
            point_valid <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        WAIT_ACK: begin
          if (point_ack) begin
            point_valid <= 1'b0;
            if (point_idx == last_idx) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= SETTLE;
              point_idx <= point_idx + NW'(1);
              ftw_out   <= ftw_out + step_q;
              cnt       <= cnt_load(settle_q);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  ac_sweep_nco #(
    .FW(FW),
    .PW(PW)
  ) u_nco (
    .clk  (clk),
    .rst  (rst),
    .en   (busy),
    .clr  (abort),
    .ftw  (ftw_out),
    .phase(phase_out)
  );

endmodule

// File: tb/tb_ac_sweep_source.sv
// Bench for ac_sweep_source. Expected points and sweep completions are queued at stimulus time
// and consumed by an independent monitor when point_valid rises or done pulses.
module tb_ac_sweep_source;

  localparam int FW = 32;
  localparam int PW = 16;
  localparam int NW = 10;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic [FW-1:0] f_start;
  logic [FW-1:0] f_step;
  logic [NW-1:0] n_points;
  logic [CW-1:0] settle_cycles;
  logic [CW-1:0] dwell_cycles;
  logic          point_ack;
  logic [FW-1:0] ftw_out;
  logic [PW-1:0] phase_out;
  logic [NW-1:0] point_idx;
  logic          meas_en;
  logic          point_valid;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  ac_sweep_source dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .f_start      (f_start),
    .f_step       (f_step),
    .n_points     (n_points),
    .settle_cycles(settle_cycles),
    .dwell_cycles (dwell_cycles),
    .point_ack    (point_ack),
    .ftw_out      (ftw_out),
    .phase_out    (phase_out),
    .point_idx    (point_idx),
    .meas_en      (meas_en),
    .point_valid  (point_valid),
    .busy         (busy),
    .done         (done)
  );

  typedef struct {
    logic [31:0] ftw;
    int          idx;
    int          meas;
    int          settle;
  } pt_t;

  pt_t exp_pts[$];
  int  exp_done[$];
  int  errors = 0;
  int  checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_pt(input logic [31:0] ftw, input int idx, input int meas, input int settle);
    pt_t p;
    p.ftw = ftw; p.idx = idx; p.meas = meas; p.settle = settle;
    exp_pts.push_back(p);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ftw"},   ftw_out, 32'd0);
    check({tag, "_phase"}, 32'(phase_out), 32'd0);
    check({tag, "_idx"},   32'(point_idx), 32'd0);
    check({tag, "_meas"},  32'(meas_en), 32'd0);
    check({tag, "_pv"},    32'(point_valid), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
  endtask

  // Config inputs are scrambled right after start to confirm they were latched.
  task automatic start_sweep(input logic [31:0] fs, input logic [31:0] fst, input logic [9:0] np,
                             input logic [15:0] st, input logic [15:0] dw);
    @(posedge clk); #1;
    f_start = fs; f_step = fst; n_points = np; settle_cycles = st; dwell_cycles = dw; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; f_start = ~fs; f_step = 32'hDEAD_BEEF; n_points = 10'd7;
    settle_cycles = 16'd9; dwell_cycles = 16'd9;
  endtask

  task automatic wait_pv(input string name);
    int n = 0;
    while (!point_valid && n < 500) begin
      @(negedge clk);
      n++;
    end
    check({name, "_pv_timeout"}, 32'(point_valid), 32'd1);
  endtask

  task automatic ack_point(input int delay);
    wait_pv("ack");
    repeat (delay) @(posedge clk);
    @(posedge clk); #1;
    point_ack = 1'b1;
    @(posedge clk); #1;
    point_ack = 1'b0;
  endtask

  // Monitor state
  int          meas_cnt = 0;
  int          settle_cnt = 0;
  int          pts = 0;
  logic        pv_q = 1'b0;
  logic        busy_q = 1'b0;
  logic        done_q = 1'b0;
  logic        have_cur = 1'b0;
  pt_t         cur;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        meas_cnt = 0; settle_cnt = 0; pts = 0; have_cur = 1'b0;
      end else begin
        if (point_valid && !pv_q) begin
          if (exp_pts.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_point: got idx=%0d ftw=0x%0h, required no point", point_idx, ftw_out);
            have_cur = 1'b0;
          end else begin
            cur = exp_pts.pop_front();
            have_cur = 1'b1;
            check("pt_ftw", ftw_out, cur.ftw);
            check("pt_idx", 32'(point_idx), 32'(cur.idx));
            check("pt_meas_cycles", 32'(meas_cnt), 32'(cur.meas));
            check("pt_settle_cycles", 32'(settle_cnt), 32'(cur.settle));
          end
          pts++;
          meas_cnt = 0; settle_cnt = 0;
        end else if (point_valid && pv_q && have_cur) begin
          check("hold_ftw", ftw_out, cur.ftw);
          check("hold_idx", 32'(point_idx), 32'(cur.idx));
        end
        if (meas_en) meas_cnt++;
        if (busy && !meas_en && !point_valid) settle_cnt++;
        if (done) begin
          check("done_single", 32'(done_q), 32'd0);
          check("done_busy", 32'(busy), 32'd0);
          if (exp_done.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got done=1 after %0d points, required no done", pts);
          end else begin
            check("sweep_points", 32'(pts), 32'(exp_done.pop_front()));
          end
          pts = 0;
        end
        if (busy_q && !busy && !done) pts = 0;
        if (!busy) begin meas_cnt = 0; settle_cnt = 0; end
      end
      pv_q = point_valid; busy_q = busy; done_q = done;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  logic [15:0] nco_exp [7];

  initial begin : stim
    int n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; point_ack = 1'b0;
    f_start = '0; f_step = '0; n_points = '0; settle_cycles = '0; dwell_cycles = '0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    check_idle_outputs("reset");

    // NCO sequence and phase continuity across a step 0x40000000 -> 0x20000000
    nco_exp = '{16'h0000, 16'h4000, 16'h8000, 16'hC000, 16'h0000, 16'h2000, 16'h4000};
    push_pt(32'h4000_0000, 0, 1, 1);
    push_pt(32'h2000_0000, 1, 1, 1);
    exp_done.push_back(2);
    start_sweep(32'h4000_0000, 32'hE000_0000, 10'd2, 16'd0, 16'd1);
    check("nco_phase_p0", 32'(phase_out), 32'h0000);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      check($sformatf("nco_phase_%0d", i + 1), 32'(phase_out), 32'(nco_exp[i]));
      if (i == 3) check("nco_ftw_stepped", ftw_out, 32'h2000_0000);
      point_ack = (i == 2);
    end
    point_ack = 1'b0;
    ack_point(0);
    repeat (3) @(posedge clk); #1;
    check("nco_busy_after", 32'(busy), 32'd0);
    check("done_ftw_hold", ftw_out, 32'h2000_0000);

    // Basic three-point sweep
    push_pt(32'h1000_0000, 0, 4, 2);
    push_pt(32'h1100_0000, 1, 4, 2);
    push_pt(32'h1200_0000, 2, 4, 2);
    exp_done.push_back(3);
    start_sweep(32'h1000_0000, 32'h0100_0000, 10'd3, 16'd2, 16'd4);
    check("basic_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 3; i++) ack_point(1);
    repeat (3) @(posedge clk); #1;
    check("basic_busy_after", 32'(busy), 32'd0);

    // Zero points: done on the cycle after start, nothing produced
    exp_done.push_back(0);
    start_sweep(32'h0000_0001, 32'h0000_0001, 10'd0, 16'd2, 16'd2);
    check("np0_done", 32'(done), 32'd1);
    check("np0_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("np0_done_clear", 32'(done), 32'd0);

    // settle=0 and dwell=0 each take exactly one cycle
    push_pt(32'h0000_1234, 0, 1, 1);
    push_pt(32'h0000_1235, 1, 1, 1);
    exp_done.push_back(2);
    start_sweep(32'h0000_1234, 32'h0000_0001, 10'd2, 16'd0, 16'd0);
    for (int i = 0; i < 2; i++) ack_point(0);
    repeat (3) @(posedge clk);

    // Backpressure with a repeated frequency and a stray ack in DWELL
    push_pt(32'h0800_0000, 0, 4, 3);
    push_pt(32'h0800_0000, 1, 4, 3);
    exp_done.push_back(2);
    start_sweep(32'h0800_0000, 32'h0000_0000, 10'd2, 16'd3, 16'd4);
    n = 0;
    while (!meas_en && n < 100) begin @(negedge clk); n++; end
    check("bp_dwell_seen", 32'(meas_en), 32'd1);
    @(posedge clk); #1; point_ack = 1'b1;
    @(posedge clk); #1; point_ack = 1'b0;
    wait_pv("bp");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 32'(point_valid), 32'd1);
    end
    point_ack = 1'b1;
    @(posedge clk); #1; point_ack = 1'b0;
    check("bp_valid_drop", 32'(point_valid), 32'd0);
    check("bp_idx_next", 32'(point_idx), 32'd1);
    ack_point(0);
    repeat (3) @(posedge clk);

    // FTW wraps modulo 2^32
    push_pt(32'hFFFF_FF00, 0, 1, 1);
    push_pt(32'h0000_0100, 1, 1, 1);
    exp_done.push_back(2);
    start_sweep(32'hFFFF_FF00, 32'h0000_0200, 10'd2, 16'd1, 16'd1);
    for (int i = 0; i < 2; i++) ack_point(0);
    repeat (3) @(posedge clk);

    // Abort in DWELL of point 1: clean idle, no done
    push_pt(32'h3000_0000, 0, 5, 1);
    start_sweep(32'h3000_0000, 32'h0100_0000, 10'd3, 16'd1, 16'd5);
    ack_point(0);
    n = 0;
    while (!(meas_en && point_idx == 10'd1) && n < 200) begin @(negedge clk); n++; end
    check("abort_reach_dwell1", 32'(meas_en && point_idx == 10'd1), 32'd1);
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    check_idle_outputs("abort");
    repeat (5) @(posedge clk); #1;
    check("abort_stays_idle", 32'(busy), 32'd0);

    // start together with abort in IDLE must not start
    start = 1'b1; abort = 1'b1; n_points = 10'd1;
    f_start = 32'h7777_0000; settle_cycles = 16'd1; dwell_cycles = 16'd1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    check("start_abort_busy", 32'(busy), 32'd0);
    check("start_abort_ftw", ftw_out, 32'd0);
    repeat (3) @(posedge clk); #1;
    check("start_abort_idle", 32'(busy | point_valid | meas_en), 32'd0);

    // rst while waiting for ack, then a clean restart from point 0
    push_pt(32'h0500_0000, 0, 2, 1);
    start_sweep(32'h0500_0000, 32'h0010_0000, 10'd2, 16'd0, 16'd2);
    wait_pv("rst");
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check_idle_outputs("rst_mid");
    push_pt(32'h0500_0000, 0, 2, 1);
    push_pt(32'h0510_0000, 1, 2, 1);
    exp_done.push_back(2);
    start_sweep(32'h0500_0000, 32'h0010_0000, 10'd2, 16'd0, 16'd2);
    check("restart_idx", 32'(point_idx), 32'd0);
    for (int i = 0; i < 2; i++) ack_point(0);
    repeat (5) @(posedge clk); #1;

    check("leftover_points", 32'(exp_pts.size()), 32'd0);
    check("leftover_dones", 32'(exp_done.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
